// File: rtl/puc_pkg.sv
// Shared defaults and types for the instruction prefetch stage.
package puc_pkg;

  localparam int PC_WIDTH_DEF          = 8;
  localparam int INSTRUCTION_WIDTH_DEF = 32;
  localparam int DEPTH_DEF             = 4;

  typedef struct packed {
    logic [PC_WIDTH_DEF-1:0]          pc;
    logic [INSTRUCTION_WIDTH_DEF-1:0] instruction;
  } fetch_entry_t;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Circular buffer of fetched {pc, instruction} entries with single-cycle flush.
// Head is driven straight from storage and reads as zero when empty.
module prefetch_fifo
  import puc_pkg::*;
#(
  parameter int  DEPTH   = DEPTH_DEF,
  parameter type entry_t = fetch_entry_t,
  localparam int AW      = $clog2(DEPTH),
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          isResetN,
  input  logic          flush,
  input  logic          push,
  input  entry_t        push_data,
  input  logic          pop,
  output entry_t        head,
  output logic [CW-1:0] count
);

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clock or negedge isResetN) begin
    if (!isResetN) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count = count_q;

endmodule

// File: rtl/instruction_prefetch.sv
// Fetch stage: credit-limited instruction memory reads feeding a prefetch FIFO,
// flushed on core redirect. Optional PREFETCH_FLUSH_COUNT_EN adds a flushCount output.
module instruction_prefetch
  import puc_pkg::*;
#(
  parameter int PC_WIDTH          = PC_WIDTH_DEF,
  parameter int INSTRUCTION_WIDTH = INSTRUCTION_WIDTH_DEF,
  parameter int DEPTH             = DEPTH_DEF
) (
  input  logic                         clock,
  input  logic                         isResetN,
  input  logic                         redirect,
  input  logic [PC_WIDTH-1:0]          redirectPc,
  output logic                         memRead,
  output logic [PC_WIDTH-1:0]          memAddress,
  input  logic [INSTRUCTION_WIDTH-1:0] memInstruction,
  output logic                         instructionValid,
  output logic [INSTRUCTION_WIDTH-1:0] instruction,
  output logic [PC_WIDTH-1:0]          instructionPc,
  input  logic                         instructionReady
`ifdef PREFETCH_FLUSH_COUNT_EN
  ,
  output logic [15:0]                  flushCount
`endif
);

  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [PC_WIDTH-1:0]          pc;
    logic [INSTRUCTION_WIDTH-1:0] instruction;
  } entry_t;

  logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic                inflight_q, inflight_d;
  logic [CW-1:0]       count;
  logic [CW:0]         credit;
  logic                issue, push, pop;
  entry_t              push_data, head;

  // Outstanding read counts against FIFO space so a response always has a slot.
  assign credit = {1'b0, count} + (CW+1)'(inflight_q);
  assign issue  = isResetN & ~redirect & (credit < (CW+1)'(DEPTH));
  assign push   = inflight_q & ~redirect;
  assign pop    = instructionValid & instructionReady & ~redirect;

  assign push_data.pc          = inflight_pc_q;
  assign push_data.instruction = memInstruction;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = issue;
    if (redirect) begin
      fetch_pc_d = redirectPc;
    end else if (issue) begin
      fetch_pc_d    = fetch_pc_q + PC_WIDTH'(1);
      inflight_pc_d = fetch_pc_q;
    end
  end

  always_ff @(posedge clock or negedge isResetN) begin
    if (!isResetN) begin
      fetch_pc_q    <= '0;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
    end
  end

  prefetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clock     (clock),
    .isResetN  (isResetN),
    .flush     (redirect),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  assign memRead          = issue;
  assign memAddress       = fetch_pc_q;
  assign instructionValid = (count != '0);
  assign instruction      = head.instruction;
  assign instructionPc    = head.pc;

`ifdef PREFETCH_FLUSH_COUNT_EN
  logic [15:0] flush_count_q, flush_count_d;

  always_comb begin
    flush_count_d = flush_count_q;
    if (redirect) flush_count_d = sat_add16(flush_count_q, 16'(credit));
  end

  always_ff @(posedge clock or negedge isResetN) begin
    if (!isResetN) flush_count_q <= '0;
    else           flush_count_q <= flush_count_d;
  end

  assign flushCount = flush_count_q;
`endif

endmodule

// File: tb/tb_instruction_prefetch.sv
// Bench for instruction_prefetch: directed vector table, hand-written corner
// sequences and random traffic checked against a queue-based reference model.
module tb_instruction_prefetch;

  localparam int D = 4;

  logic        clock = 1'b0;
  logic        isResetN = 1'b0;
  logic        redirect = 1'b0;
  logic [7:0]  redirectPc = '0;
  logic        memRead;
  logic [7:0]  memAddress;
  logic [31:0] memInstruction = '0;
  logic        instructionValid;
  logic [31:0] instruction;
  logic [7:0]  instructionPc;
  logic        instructionReady = 1'b0;
`ifdef PREFETCH_FLUSH_COUNT_EN
  logic [15:0] flushCount;
`endif

  always #5 clock = ~clock;

  instruction_prefetch dut (
    .clock            (clock),
    .isResetN         (isResetN),
    .redirect         (redirect),
    .redirectPc       (redirectPc),
    .memRead          (memRead),
    .memAddress       (memAddress),
    .memInstruction   (memInstruction),
    .instructionValid (instructionValid),
    .instruction      (instruction),
    .instructionPc    (instructionPc),
    .instructionReady (instructionReady)
`ifdef PREFETCH_FLUSH_COUNT_EN
    ,
    .flushCount       (flushCount)
`endif
  );

  // Synchronous memory: mem[a] = 32'hA0 + a, garbage on non-read cycles.
  always @(posedge clock) begin
    if (memRead) memInstruction <= 32'hA0 + 32'(memAddress);
    else         memInstruction <= $urandom;
  end

  int checks = 0;
  int failures = 0;

  // Reference model: next fetch address, one optional outstanding read, queue of PCs.
  int m_fpc;
  bit m_infl;
  int m_inflpc;
  int m_q[$];
  int m_flush;
  int delivered[$];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_fpc = 0; m_infl = 0; m_inflpc = 0; m_flush = 0;
    m_q.delete();
  endfunction

  task automatic step(input bit rstn, input bit redir, input logic [7:0] rpc, input bit rdy,
                      output logic a_read, output logic [7:0] a_addr,
                      output logic a_valid, output logic [7:0] a_pc);
    bit e_read, e_valid;
    int e_pc;
    @(negedge clock);
    isResetN = rstn; redirect = redir; redirectPc = rpc; instructionReady = rdy;
    if (!rstn) model_reset();
    #1;
    e_read  = rstn && !redir && (m_q.size() + int'(m_infl) < D);
    e_valid = m_q.size() != 0;
    e_pc    = e_valid ? m_q[0] : 0;
    chk("memRead", 32'(memRead), 32'(e_read));
    chk("memAddress", 32'(memAddress), 32'(m_fpc));
    chk("instructionValid", 32'(instructionValid), 32'(e_valid));
    chk("instructionPc", 32'(instructionPc), 32'(e_pc));
    chk("instruction", instruction, e_valid ? 32'hA0 + 32'(e_pc) : 32'h0);
`ifdef PREFETCH_FLUSH_COUNT_EN
    chk("flushCount", 32'(flushCount), 32'(m_flush));
`endif
    a_read = memRead; a_addr = memAddress; a_valid = instructionValid; a_pc = instructionPc;
    if (rstn && !redir && rdy && instructionValid) delivered.push_back(int'(instructionPc));
    @(posedge clock);
    if (rstn) begin
      if (redir) begin
        m_flush = m_flush + m_q.size() + int'(m_infl);
        if (m_flush > 65535) m_flush = 65535;
        m_q.delete();
        m_infl = 0;
        m_fpc  = int'(rpc);
      end else begin
        if (e_valid && rdy) void'(m_q.pop_front());
        if (m_infl) m_q.push_back(m_inflpc);
        if (e_read) begin
          m_inflpc = m_fpc;
          m_fpc    = (m_fpc + 1) % 256;
          m_infl   = 1;
        end else begin
          m_infl = 0;
        end
      end
    end
  endtask

  typedef struct {
    bit         rstn, redir, rdy;
    logic [7:0] rpc;
    bit         e_read;
    logic [7:0] e_addr;
    bit         e_valid;
    logic [7:0] e_pc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit rstn, bit rdy, bit e_read, logic [7:0] e_addr,
                              bit e_valid, logic [7:0] e_pc);
    vec_t v;
    v.rstn = rstn; v.redir = 1'b0; v.rpc = '0; v.rdy = rdy;
    v.e_read = e_read; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
    return v;
  endfunction

  logic       a_read, a_valid;
  logic [7:0] a_addr, a_pc;
  bit         saw10;

  initial begin
    model_reset();
    // Reset release with ready high: streaming from PC 0.
    vecs.push_back(mk(0, 1, 0, 8'h00, 0, 8'h00));
    vecs.push_back(mk(1, 1, 1, 8'h00, 0, 8'h00));
    vecs.push_back(mk(1, 1, 1, 8'h01, 0, 8'h00));
    vecs.push_back(mk(1, 1, 1, 8'h02, 1, 8'h00));
    vecs.push_back(mk(1, 1, 1, 8'h03, 1, 8'h01));
    vecs.push_back(mk(1, 1, 1, 8'h04, 1, 8'h02));
    vecs.push_back(mk(1, 1, 1, 8'h05, 1, 8'h03));
    // Ready low: FIFO fills to DEPTH and fetching stalls, then drains.
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 8'h00));
    vecs.push_back(mk(1, 0, 1, 8'h00, 0, 8'h00));
    vecs.push_back(mk(1, 0, 1, 8'h01, 0, 8'h00));
    vecs.push_back(mk(1, 0, 1, 8'h02, 1, 8'h00));
    vecs.push_back(mk(1, 0, 1, 8'h03, 1, 8'h00));
    vecs.push_back(mk(1, 0, 0, 8'h04, 1, 8'h00));
    vecs.push_back(mk(1, 0, 0, 8'h04, 1, 8'h00));
    vecs.push_back(mk(1, 0, 0, 8'h04, 1, 8'h00));
    vecs.push_back(mk(1, 1, 0, 8'h04, 1, 8'h00));
    vecs.push_back(mk(1, 1, 1, 8'h04, 1, 8'h01));
    vecs.push_back(mk(1, 1, 1, 8'h05, 1, 8'h02));
    vecs.push_back(mk(1, 1, 1, 8'h06, 1, 8'h03));
    vecs.push_back(mk(1, 1, 1, 8'h07, 1, 8'h04));

    foreach (vecs[i]) begin
      step(vecs[i].rstn, vecs[i].redir, vecs[i].rpc, vecs[i].rdy, a_read, a_addr, a_valid, a_pc);
      chk($sformatf("vec%0d.read", i), 32'(a_read), 32'(vecs[i].e_read));
      if (vecs[i].rstn) chk($sformatf("vec%0d.addr", i), 32'(a_addr), 32'(vecs[i].e_addr));
      chk($sformatf("vec%0d.valid", i), 32'(a_valid), 32'(vecs[i].e_valid));
      chk($sformatf("vec%0d.pc", i), 32'(a_pc), 32'(vecs[i].e_pc));
    end

    // Redirect with count=3, inflight=1: stale response dropped, refetch from 8'h40.
    step(0, 0, 8'h00, 0, a_read, a_addr, a_valid, a_pc);
    repeat (4) step(1, 0, 8'h00, 0, a_read, a_addr, a_valid, a_pc);
    delivered.delete();
    step(1, 1, 8'h40, 1, a_read, a_addr, a_valid, a_pc);
    chk("redir.memRead", 32'(a_read), 32'h0);
    step(1, 0, 8'h00, 1, a_read, a_addr, a_valid, a_pc);
    chk("redir.valid_next", 32'(a_valid), 32'h0);
    chk("redir.addr_next", 32'(a_addr), 32'h40);
    chk("redir.read_next", 32'(a_read), 32'h1);
`ifdef PREFETCH_FLUSH_COUNT_EN
    chk("redir.flushCount", 32'(flushCount), 32'd4);
`endif
    repeat (4) step(1, 0, 8'h00, 1, a_read, a_addr, a_valid, a_pc);
    chk("redir.first_pc", (delivered.size() > 0) ? 32'(delivered[0]) : 32'hFFFF_FFFF, 32'h40);

    // PC wrap from FF to 00.
    delivered.delete();
    step(1, 1, 8'hFE, 1, a_read, a_addr, a_valid, a_pc);
    repeat (8) step(1, 0, 8'h00, 1, a_read, a_addr, a_valid, a_pc);
    for (int i = 0; i < 4; i++)
      chk($sformatf("wrap.pc%0d", i), (delivered.size() > i) ? 32'(delivered[i]) : 32'hFFFF_FFFF,
          32'((8'hFE + i) % 256));

    // Back-to-back redirects: only the last target is fetched.
    delivered.delete();
    step(1, 1, 8'h10, 1, a_read, a_addr, a_valid, a_pc);
    step(1, 1, 8'h20, 1, a_read, a_addr, a_valid, a_pc);
    repeat (8) step(1, 0, 8'h00, 1, a_read, a_addr, a_valid, a_pc);
    chk("b2b.first_pc", (delivered.size() > 0) ? 32'(delivered[0]) : 32'hFFFF_FFFF, 32'h20);
    saw10 = 0;
    foreach (delivered[i]) if (delivered[i] == 'h10) saw10 = 1;
    chk("b2b.no_pc10", 32'(saw10), 32'h0);

    // Asynchronous reset mid-stream with count=2, inflight=1.
    step(0, 0, 8'h00, 0, a_read, a_addr, a_valid, a_pc);
    repeat (3) step(1, 0, 8'h00, 0, a_read, a_addr, a_valid, a_pc);
    step(0, 0, 8'h00, 0, a_read, a_addr, a_valid, a_pc);
    chk("rst.valid", 32'(a_valid), 32'h0);
    chk("rst.read", 32'(a_read), 32'h0);
    step(1, 0, 8'h00, 1, a_read, a_addr, a_valid, a_pc);
    chk("rst.restart_read", 32'(a_read), 32'h1);
    chk("rst.restart_addr", 32'(a_addr), 32'h0);

    // Random traffic against the reference model.
    for (int n = 0; n < 1500; n++) begin
      bit r_rst, r_red, r_rdy;
      r_rst = ($urandom_range(0, 99) != 0);
      r_red = ($urandom_range(0, 99) < 6);
      r_rdy = ($urandom_range(0, 99) < 70);
      step(r_rst, r_red, 8'($urandom), r_rdy, a_read, a_addr, a_valid, a_pc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
